// File: rtl/audio_tone_pkg.sv
// audio_tone_pkg: shared encodings for the multi-channel test-tone generator
package audio_tone_pkg;
    localparam int GAIN_W = 3;
    typedef enum logic [1:0] {MODE_SAW = 2'd0, MODE_SQUARE = 2'd1, MODE_TRI = 2'd2, MODE_MUTE = 2'd3} mode_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_EMIT = 2'd2} state_e;
endpackage

// File: rtl/audio_wave_shaper.sv
// audio_wave_shaper: maps a phase slice to a signed saw/square/triangle/mute sample,
// then attenuates it by an arithmetic right shift.
module audio_wave_shaper
    import audio_tone_pkg::*;
#(
    parameter int AUDIO_WIDTH = 16
) (
    input  logic [AUDIO_WIDTH-1:0] p_i,
    input  logic [1:0]             mode_i,
    input  logic [GAIN_W-1:0]      gain_i,
    output logic [AUDIO_WIDTH-1:0] sample_o
);
    localparam int M = AUDIO_WIDTH - 1;
    logic [M:0] saw_w, sq_w, u_w, tri_w, wave_w;
    assign saw_w = {~p_i[M], p_i[M-1:0]};
    assign sq_w  = p_i[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
    // fold the second half of the period back down to get a symmetric ramp
    assign u_w   = p_i[M] ? ~{p_i[M-1:0], 1'b0} : {p_i[M-1:0], 1'b0};
    assign tri_w = {~u_w[M], u_w[M-1:0]};
    always_comb begin
        wave_w = mode_i == MODE_SAW    ? saw_w :
                 mode_i == MODE_SQUARE ? sq_w  :
                 mode_i == MODE_TRI    ? tri_w : '0;
    end
    assign sample_o = $signed(wave_w) >>> gain_i;
endmodule

// File: rtl/audio_tone_gen.sv
// audio_tone_gen: multi-channel phase-accumulator tone source; channels share one
// shaper, one CALC cycle each, and the packed frame is written out on an en/full handshake.
module audio_tone_gen
    import audio_tone_pkg::*;
#(
    parameter int AUDIO_WIDTH = 16,
    parameter int CHANNELS    = 2,
    parameter int PHASE_WIDTH = 24
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            phase_clr,
    input  logic [CHANNELS*PHASE_WIDTH-1:0] phase_inc,
    input  logic [CHANNELS*2-1:0]           mode,
    input  logic [CHANNELS*GAIN_W-1:0]      gain_shift,
    input  logic                            full_in,
    output logic [CHANNELS*AUDIO_WIDTH-1:0] data_out,
    output logic                            en_out
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

    state_e                          state_q, state_d;
    logic [CW-1:0]                   ch_q, ch_d;
    logic [PHASE_WIDTH-1:0]          phase_q [CHANNELS];
    logic [PHASE_WIDTH-1:0]          phase_d [CHANNELS];
    logic [AUDIO_WIDTH-1:0]          slot_q  [CHANNELS];
    logic [AUDIO_WIDTH-1:0]          slot_d  [CHANNELS];
    logic [CHANNELS*AUDIO_WIDTH-1:0] data_q, data_d, packed_w;
    logic                            en_q, en_d;
    logic [AUDIO_WIDTH-1:0]          sample_w;

    audio_wave_shaper #(.AUDIO_WIDTH(AUDIO_WIDTH)) u_shaper (
        .p_i      (phase_q[ch_q][PHASE_WIDTH-1 -: AUDIO_WIDTH]),
        .mode_i   (mode[ch_q*2 +: 2]),
        .gain_i   (gain_shift[ch_q*GAIN_W +: GAIN_W]),
        .sample_o (sample_w)
    );

    // channel 0 is the left sample and lands in the most significant bits
    always_comb begin
        packed_w = '0;
        for (int k = 0; k < CHANNELS; k++)
            packed_w[(CHANNELS-1-k)*AUDIO_WIDTH +: AUDIO_WIDTH] = slot_q[k];
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        phase_d = phase_q;
        slot_d  = slot_q;
        data_d  = data_q;
        en_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = enable ? ST_CALC : ST_IDLE;
                ch_d    = '0;
            end
            ST_CALC: begin
                slot_d[ch_q]  = sample_w;
                phase_d[ch_q] = phase_q[ch_q] + phase_inc[ch_q*PHASE_WIDTH +: PHASE_WIDTH];
                ch_d          = ch_q == LAST ? '0 : ch_q + CW'(1);
                state_d       = ch_q == LAST ? ST_EMIT : ST_CALC;
            end
            ST_EMIT: begin
                data_d  = full_in ? data_q : packed_w;
                en_d    = ~full_in;
                state_d = full_in ? ST_EMIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // a clear aborts whatever frame is in flight, including a pending write
        if (phase_clr) begin
            state_d = ST_IDLE;
            ch_d    = '0;
            en_d    = 1'b0;
            data_d  = data_q;
            for (int k = 0; k < CHANNELS; k++)
                phase_d[k] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                phase_q[k] <= '0;
                slot_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            en_q    <= en_d;
            phase_q <= phase_d;
            slot_q  <= slot_d;
        end
    end

    assign data_out = data_q;
    assign en_out   = en_q;
endmodule

// File: tb/tb_audio_tone_gen.sv
// tb_audio_tone_gen: scoreboard bench; a behavioural phase/waveform model queues
// expected frames and a monitor checks every en_out against them.
module tb_audio_tone_gen;
    localparam int AW = 16;
    localparam int CH = 2;
    localparam int PW = 24;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             phase_clr = 1'b0;
    logic [CH*PW-1:0] phase_inc = '0;
    logic [CH*2-1:0]  mode = '0;
    logic [CH*3-1:0]  gain_shift = '0;
    logic             full_in = 1'b0;
    logic [CH*AW-1:0] data_out;
    logic             en_out;

    audio_tone_gen #(.AUDIO_WIDTH(AW), .CHANNELS(CH), .PHASE_WIDTH(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .phase_clr  (phase_clr),
        .phase_inc  (phase_inc),
        .mode       (mode),
        .gain_shift (gain_shift),
        .full_in    (full_in),
        .data_out   (data_out),
        .en_out     (en_out)
    );

    always #5 clk = ~clk;

    int               n_vec = 0;
    int               n_err = 0;
    int               en_cnt = 0;
    logic [CH*AW-1:0] exp_q[$];
    logic [CH*AW-1:0] last_exp = '0;
    logic [PW-1:0]    m_ph   [CH];
    logic [PW-1:0]    m_inc  [CH];
    logic [1:0]       m_mode [CH];
    logic [2:0]       m_gain [CH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] model_wave(input logic [AW-1:0] p, input logic [1:0] m, input logic [2:0] g);
        logic [AW-1:0] v;
        int            u;
        case (m)
            2'd0: v = p ^ 16'h8000;
            2'd1: v = (p >= 16'h8000) ? 16'h8000 : 16'h7FFF;
            2'd2: begin
                u = (p < 16'h8000) ? 2 * int'(p) : 65535 - 2 * (int'(p) - 32768);
                v = 16'(u) ^ 16'h8000;
            end
            default: v = '0;
        endcase
        return 16'($signed(v) >>> g);
    endfunction

    task automatic set_cfg(input int k, input logic [1:0] m, input logic [PW-1:0] inc, input logic [2:0] g);
        m_mode[k] = m;
        m_inc[k]  = inc;
        m_gain[k] = g;
        mode[k*2 +: 2]        = m;
        phase_inc[k*PW +: PW] = inc;
        gain_shift[k*3 +: 3]  = g;
    endtask

    task automatic push_frames(input int n);
        logic [CH*AW-1:0] f;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < CH; k++) begin
                f[(CH-1-k)*AW +: AW] = model_wave(m_ph[k][PW-1 -: AW], m_mode[k], m_gain[k]);
                m_ph[k] = m_ph[k] + m_inc[k];
            end
            exp_q.push_back(f);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input int target);
        for (int c = 0; c < 200 && en_cnt < target; c++) begin
            @(negedge clk);
            #1;
        end
        chk("frames_seen", en_cnt, target);
    endtask

    task automatic clr_pulse();
        tick(1);
        phase_clr = 1'b1;
        tick(1);
        phase_clr = 1'b0;
        for (int k = 0; k < CH; k++) m_ph[k] = '0;
    endtask

    always @(negedge clk) begin
        if (!reset && en_out) begin
            en_cnt++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_frame: got %0h expected no write", data_out);
            end else begin
                last_exp = exp_q.pop_front();
                chk("frame", data_out, last_exp);
            end
        end
    end

    initial begin
        int lat, b, held;
        for (int k = 0; k < CH; k++) begin
            m_ph[k] = '0;
            set_cfg(k, 2'd3, '0, 3'd0);
        end
        tick(3);
        @(negedge clk);
        chk("reset_en", en_out, 0);
        chk("reset_data", data_out, 0);
        tick(1);
        reset = 1'b0;

        // startup saw: latency and period
        set_cfg(0, 2'd0, 24'h010000, 3'd0);
        set_cfg(1, 2'd3, 24'h0, 3'd0);
        push_frames(3);
        tick(1);
        enable = 1'b1;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick(1);
            if (en_out) lat = c;
        end
        chk("first_en_latency", lat, 4);
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick(1);
            if (en_out) lat = c;
        end
        chk("frame_period", lat, 4);
        wait_en(3);
        enable = 1'b0;

        // square with gain
        set_cfg(0, 2'd1, 24'h800000, 3'd0);
        set_cfg(1, 2'd1, 24'h800000, 3'd3);
        clr_pulse();
        push_frames(4);
        b = en_cnt;
        enable = 1'b1;
        wait_en(b + 4);
        enable = 1'b0;

        // triangle
        set_cfg(0, 2'd2, 24'h400000, 3'd0);
        set_cfg(1, 2'd3, 24'h0, 3'd0);
        clr_pulse();
        push_frames(5);
        b = en_cnt;
        enable = 1'b1;
        wait_en(b + 5);
        enable = 1'b0;

        // backpressure
        set_cfg(0, 2'd0, 24'h123456, 3'd0);
        set_cfg(1, 2'd2, 24'h0F0000, 3'd1);
        clr_pulse();
        push_frames(1);
        b = en_cnt;
        full_in = 1'b1;
        enable = 1'b1;
        tick(3);
        enable = 1'b0;
        held = 0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            held += int'(en_out);
        end
        chk("bp_no_en", held, 0);
        chk("bp_data_hold", data_out, last_exp);
        full_in = 1'b0;
        wait_en(b + 1);
        tick(6);
        chk("bp_single_en", en_cnt, b + 1);
        push_frames(1);
        enable = 1'b1;
        wait_en(b + 2);
        enable = 1'b0;

        // phase_clr during CALC of ch1
        set_cfg(0, 2'd0, 24'hFFFFFF, 3'd0);
        set_cfg(1, 2'd0, 24'h200000, 3'd2);
        clr_pulse();
        push_frames(2);
        b = en_cnt;
        enable = 1'b1;
        wait_en(b + 2);
        b = en_cnt;
        tick(2);
        phase_clr = 1'b1;
        enable = 1'b0;
        tick(1);
        phase_clr = 1'b0;
        for (int k = 0; k < CH; k++) m_ph[k] = '0;
        tick(6);
        chk("clr_no_en", en_cnt, b);
        chk("clr_data_hold", data_out, last_exp);
        push_frames(3);
        enable = 1'b1;
        wait_en(b + 3);
        enable = 1'b0;

        // reset while stalled in EMIT
        set_cfg(0, 2'd0, 24'h010000, 3'd0);
        set_cfg(1, 2'd3, 24'h0, 3'd0);
        tick(1);
        full_in = 1'b1;
        enable = 1'b1;
        tick(4);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_en", en_out, 0);
        chk("midrst_data", data_out, 0);
        enable = 1'b0;
        full_in = 1'b0;
        tick(2);
        reset = 1'b0;
        for (int k = 0; k < CH; k++) m_ph[k] = '0;
        push_frames(1);
        b = en_cnt;
        enable = 1'b1;
        wait_en(b + 1);
        enable = 1'b0;
        tick(6);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/audio_tone_gen.md
Name: audio_tone_gen

Overview:
- Parametrised multi-channel test-tone source. It replaces the fixed two-channel sawtooth generator that feeds the audio CDC FIFO.
- Each channel has a phase accumulator with per-channel increment, waveform mode and gain shift.
- Channels are computed time-multiplexed through one shared waveform shaper. The packed frame is pushed with an en/full handshake into the audio FIFO's write side (system clock domain).

Parameters:
- AUDIO_WIDTH, 16, sample width per channel (signed, two's complement)
- CHANNELS, 2, number of channels, 1..8
- PHASE_WIDTH, 24, phase accumulator width; must be >= AUDIO_WIDTH

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; allows new frames to start
- phase_clr  in  1  single-cycle pulse; zero all phases, abort current frame
- phase_inc  in  CHANNELS*PHASE_WIDTH  channel k at [k*PHASE_WIDTH +: PHASE_WIDTH]
- mode  in  CHANNELS*2  channel k at [k*2 +: 2]; 0 saw, 1 square, 2 triangle, 3 mute
- gain_shift  in  CHANNELS*3  channel k at [k*3 +: 3]; arithmetic right shift 0..7
- full_in  in  1  downstream FIFO full
- data_out  out  CHANNELS*AUDIO_WIDTH  channel k at [(CHANNELS-1-k)*AUDIO_WIDTH +: AUDIO_WIDTH] (ch0 = left, in MSBs)
- en_out  out  1  one-cycle write strobe, registered

Behaviour:
- Reset (async assert, synchronous deassert handled upstream):
  - state IDLE, ch counter 0, all phases 0, slot registers 0
  - data_out 0, en_out 0
- FSM states: IDLE, CALC, EMIT.
- IDLE: if enable=1, go to CALC with ch=0. Otherwise stay; phases hold.
- CALC (one cycle per channel):
  - p = phase[ch][PHASE_WIDTH-1 -: AUDIO_WIDTH], taken from the pre-increment phase.
  - slot[ch] = shaper(p, mode[ch]) >>> gain_shift[ch].
  - phase[ch] <= phase[ch] + phase_inc[ch], modulo 2^PHASE_WIDTH (silent wrap).
  - If ch == CHANNELS-1, go to EMIT; else ch+1.
- EMIT:
  - If full_in=0: data_out <= packed slots, en_out <= 1 for one cycle, go to IDLE.
  - Otherwise hold in EMIT. data_out and phases are unchanged, en_out stays 0.
- Frame period with no backpressure: CHANNELS+2 cycles (IDLE, CHANNELS x CALC, EMIT). en_out is visible the cycle after the EMIT cycle.
- Shaper, with M = AUDIO_WIDTH-1:
  - saw = {~p[M], p[M-1:0]}
  - square = p[M] ? min negative (0x8000 @16b) : max positive (0x7FFF)
  - triangle: u = p[M] ? ~{p[M-1:0],1'b0} : {p[M-1:0],1'b0}; tri = {~u[M], u[M-1:0]}
  - mute = 0
- Config inputs are sampled per channel in that channel's CALC cycle. Mid-frame changes affect only channels not yet computed.
- enable dropping mid-frame: the frame completes, including EMIT, then the FSM idles.
- phase_clr, any state: all phases <= 0, ch <= 0, state <= IDLE, no en_out for the aborted frame. data_out keeps its last value. It overrides the EMIT transition in the same cycle.
- Async reset mid-frame: immediate return to reset values. No partial frame is emitted.

Decomposition:
- Package audio_tone_pkg holds:
  - mode encodings: MODE_SAW, MODE_SQUARE, MODE_TRI, MODE_MUTE
  - FSM state encodings
  - gain-shift width constant (3)
- Sub-module audio_wave_shaper: purely combinational (p, mode, gain_shift -> sample), parametrised by AUDIO_WIDTH. It is unit-tested separately.
- Phase accumulators are a register array in the top block.

Test Plan (AUDIO_WIDTH=16, CHANNELS=2, PHASE_WIDTH=24):
1. Startup and saw:
   - Stimulus: reset released; enable=1, full_in=0; ch0 saw inc 0x010000; ch1 mute.
   - Response: first en_out 4 cycles after enable is seen in IDLE, with data_out=0x8000_0000. The next frame gives 0x8100_0000. en_out repeats every 4 cycles.
2. Square with gain:
   - Stimulus: ch0 square inc 0x800000 gain 0; ch1 square same inc gain 3.
   - Response: frames alternate 0x7FFF_0FFF and 0x8000_F000.
3. Triangle:
   - Stimulus: ch0 tri inc 0x400000.
   - Response: ch0 sequence 0x8000, 0x0000, 0x7FFF, 0xFFFF, then repeats (wrap at 0xC00000 + 0x400000 = 0).
4. Backpressure:
   - Stimulus: full_in=1 held 5 cycles while in EMIT.
   - Response: no en_out during the hold. Exactly one en_out follows full_in falling, with the pre-hold values. The next frame's values show the phases advanced only once.
5. phase_clr:
   - Stimulus: phase_clr pulsed during CALC of ch1.
   - Response: no en_out for that frame. The next frame with saw gives ch0=0x8000; inc 0xFFFFFF wraps without error.
6. Reset mid-operation:
   - Stimulus: reset asserted during EMIT with full_in=1.
   - Response: en_out and data_out are 0 immediately. After release, the first frame equals the startup frame from test 1.
